// File: rtl/dbg_sel_pkg.sv
// Shared types and constants for the debug-select arbiter.
package dbg_sel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Two register stages sit between dbgsel and the mux compare.
    localparam int SETTLE   = 2;
    localparam int SETTLE_W = $clog2(SETTLE + 1);

endpackage

// File: rtl/dbg_sel_rr_arb.sv
// Round-robin picker: first set request at or after i_ptr wins, one-hot out.
module dbg_sel_rr_arb #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_win
);

    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                o_win[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dbg_sel_arbiter.sv
// Debug-bus ownership arbiter: grant, settle, dwell, release.
// Define DBG_SEL_PARK_EN to return dbgsel to 0 whenever the FSM goes IDLE.
module dbg_sel_arbiter
    import dbg_sel_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SEL_W   = 8,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*SEL_W-1:0] req_sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [NREQ-1:0]       gnt,
    output logic [SEL_W-1:0]      dbgsel,
    output logic                  dbg_valid,
    output logic                  busy
);

    localparam int PTR_W = $clog2(NREQ);
`ifdef DBG_SEL_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    state_t               r_state, w_state_nxt;
    logic [NREQ-1:0]      r_gnt, w_gnt_nxt;
    logic [SEL_W-1:0]     r_sel, w_sel_nxt;
    logic                 r_valid, w_valid_nxt;
    logic [SETTLE_W-1:0]  r_settle, w_settle_nxt;
    logic [DWELL_W-1:0]   r_dwell, w_dwell_nxt;
    logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;

    logic [NREQ-1:0]      w_win;
    logic [PTR_W-1:0]     w_win_idx;
    logic [SEL_W-1:0]     w_win_sel;
    logic                 w_owner_req;

    dbg_sel_rr_arb #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_win (w_win)
    );

    always_comb begin
        w_win_idx = '0;
        w_win_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_win[k]) begin
                w_win_idx = PTR_W'(k);
                w_win_sel = req_sel[k*SEL_W +: SEL_W];
            end
        end
    end

    assign w_owner_req = |(req & r_gnt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_sel_nxt    = r_sel;
        w_valid_nxt  = r_valid;
        w_settle_nxt = r_settle;
        w_dwell_nxt  = r_dwell;
        w_ptr_nxt    = r_ptr;
        // Owner withdrawal and end of dwell share the same release path.
        if ((r_state != IDLE && !w_owner_req) ||
            (r_state == HOLD && r_dwell == DWELL_W'(1))) begin
            w_state_nxt  = IDLE;
            w_gnt_nxt    = '0;
            w_valid_nxt  = 1'b0;
            w_settle_nxt = '0;
            w_dwell_nxt  = '0;
            if (PARK) w_sel_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        w_state_nxt  = SWITCH;
                        w_gnt_nxt    = w_win;
                        w_sel_nxt    = w_win_sel;
                        w_settle_nxt = SETTLE_W'(SETTLE);
                        w_ptr_nxt    = (w_win_idx == PTR_W'(NREQ-1)) ? '0
                                                                     : w_win_idx + PTR_W'(1);
                    end
                end
                SWITCH: begin
                    if (r_settle == SETTLE_W'(1)) begin
                        w_state_nxt  = HOLD;
                        w_valid_nxt  = 1'b1;
                        w_settle_nxt = '0;
                        w_dwell_nxt  = (dwell == '0) ? DWELL_W'(1) : dwell;
                    end else begin
                        w_settle_nxt = r_settle - SETTLE_W'(1);
                    end
                end
                HOLD:    w_dwell_nxt = r_dwell - DWELL_W'(1);
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gnt    <= '0;
            r_sel    <= '0;
            r_valid  <= 1'b0;
            r_settle <= '0;
            r_dwell  <= '0;
            r_ptr    <= '0;
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_sel    <= w_sel_nxt;
            r_valid  <= w_valid_nxt;
            r_settle <= w_settle_nxt;
            r_dwell  <= w_dwell_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign dbgsel    = r_sel;
    assign dbg_valid = r_valid;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dbg_sel_arbiter.sv
// Directed-vector bench for dbg_sel_arbiter with hand-computed expectations.
module tb_dbg_sel_arbiter;

    logic        clk;
    logic        rstn;
    logic [3:0]  req;
    logic [31:0] req_sel;
    logic [7:0]  dwell;
    logic [3:0]  gnt;
    logic [7:0]  dbgsel;
    logic        dbg_valid;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

`ifdef DBG_SEL_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    dbg_sel_arbiter #(.NREQ(4), .SEL_W(8), .DWELL_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .req_sel   (req_sel),
        .dwell     (dwell),
        .gnt       (gnt),
        .dbgsel    (dbgsel),
        .dbg_valid (dbg_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] e_gnt;
        logic [7:0] e_sel;

        rstn = 1'b0; req = '0; req_sel = '0; dwell = '0;
        step(); step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(dbgsel), 32'h0);
        chk("rst_vld", 32'(dbg_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rstn = 1'b1;

        // single requester, dwell 3, select change during HOLD ignored
        req = 4'b0001; req_sel[7:0] = 8'd40; dwell = 8'd3;
        step();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_sel", 32'(dbgsel), 32'd40);
        chk("t1_vld_c1", 32'(dbg_valid), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        step();
        chk("t1_vld_c2", 32'(dbg_valid), 32'h0);
        step();
        chk("t1_vld_c3", 32'(dbg_valid), 32'h1);
        req_sel[7:0] = 8'd90;
        step();
        chk("t1_vld_c4", 32'(dbg_valid), 32'h1);
        chk("t1_sel_c4", 32'(dbgsel), 32'd40);
        step();
        chk("t1_vld_c5", 32'(dbg_valid), 32'h1);
        chk("t1_sel_c5", 32'(dbgsel), 32'd40);
        step();
        chk("t1_vld_c6", 32'(dbg_valid), 32'h0);
        chk("t1_gnt_c6", 32'(gnt), 32'h0);
        chk("t1_busy_c6", 32'(busy), 32'h0);
        chk("t1_sel_idle", 32'(dbgsel), PARK ? 32'd0 : 32'd40);
        req = '0;
        step();

        // owner drops req during HOLD
        req = 4'b0001; req_sel[7:0] = 8'd55; dwell = 8'd5;
        step();
        chk("t2_gnt", 32'(gnt), 32'h1);
        chk("t2_sel", 32'(dbgsel), 32'd55);
        step(); step();
        chk("t2_vld_hold", 32'(dbg_valid), 32'h1);
        req = '0;
        step();
        chk("t2_gnt_drop", 32'(gnt), 32'h0);
        chk("t2_vld_drop", 32'(dbg_valid), 32'h0);
        chk("t2_busy_drop", 32'(busy), 32'h0);
        chk("t2_sel_drop", 32'(dbgsel), PARK ? 32'd0 : 32'd55);
        step();

        // dwell 0 behaves as 1; pointer is at 1 so requester 1 wins
        req = 4'b0010; req_sel[15:8] = 8'h21; dwell = 8'd0;
        step();
        chk("t3_gnt", 32'(gnt), 32'h2);
        chk("t3_sel", 32'(dbgsel), 32'h21);
        step();
        chk("t3_vld_c2", 32'(dbg_valid), 32'h0);
        step();
        chk("t3_vld_c3", 32'(dbg_valid), 32'h1);
        step();
        chk("t3_vld_c4", 32'(dbg_valid), 32'h0);
        chk("t3_gnt_c4", 32'(gnt), 32'h0);
        req = '0;
        step();

        // asynchronous reset in the middle of SWITCH
        req = 4'b0100; req_sel[23:16] = 8'h77; dwell = 8'd2;
        step();
        chk("t4_gnt", 32'(gnt), 32'h4);
        chk("t4_busy", 32'(busy), 32'h1);
        #2 rstn = 1'b0;
        #1;
        chk("t4_rst_gnt", 32'(gnt), 32'h0);
        chk("t4_rst_sel", 32'(dbgsel), 32'h0);
        chk("t4_rst_vld", 32'(dbg_valid), 32'h0);
        chk("t4_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // all four requesting: strict rotation starting at 0 after reset
        req = 4'b1111; dwell = 8'd1;
        for (int k = 0; k < 4; k++) req_sel[k*8 +: 8] = 8'(8'h10 + k);
        for (int g = 0; g < 8; g++) begin
            e_gnt = 4'(1 << (g % 4));
            e_sel = 8'(8'h10 + (g % 4));
            step();
            chk($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(e_gnt));
            chk($sformatf("rr%0d_sel", g), 32'(dbgsel), 32'(e_sel));
            chk($sformatf("rr%0d_vld_sw", g), 32'(dbg_valid), 32'h0);
            step(); step();
            chk($sformatf("rr%0d_vld_hold", g), 32'(dbg_valid), 32'h1);
            step();
            chk($sformatf("rr%0d_gnt_idle", g), 32'(gnt), 32'h0);
            chk($sformatf("rr%0d_busy_idle", g), 32'(busy), 32'h0);
        end
        req = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dbg_sel_arbiter.md
DBG_SEL_ARBITER -- requirements
Module: dbg_sel_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of debug requesters, legal range 2..8.
REQ-002 The block SHALL have parameter SEL_W, default 8: width of the debug select code.
REQ-003 The block SHALL have parameter DWELL_W, default 8: width of the dwell count.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rstn SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req SHALL be an input, NREQ bits: per-requester request for debug-bus ownership.
REQ-007 Port req_sel SHALL be an input, NREQ*SEL_W bits: select code per requester; requester i occupies bits [i*SEL_W +: SEL_W].
REQ-008 Port dwell SHALL be an input, DWELL_W bits: number of valid-window cycles per grant.
REQ-009 Port gnt SHALL be an output, NREQ bits: one-hot grant, all zero when no owner.
REQ-010 Port dbgsel SHALL be an output, SEL_W bits, registered: select code driven to the debug mux tree.
REQ-011 Port dbg_valid SHALL be an output, 1 bit, registered: debug data from the owner is stable at the mux outputs.
REQ-012 Port busy SHALL be an output, 1 bit: the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SWITCH and HOLD.
REQ-014 In IDLE with any req bit set, the block SHALL pick a winner round-robin in the same cycle; on the next edge it SHALL set gnt to the winner, load dbgsel from the winner's req_sel, load the settle counter with SETTLE, and enter SWITCH.
REQ-015 Round-robin priority SHALL start at the index after the last winner; after reset the pointer SHALL be 0, so index 0 has highest priority.
REQ-016 In SWITCH, dbg_valid SHALL be 0 and the settle counter SHALL decrement each cycle.
REQ-017 SWITCH SHALL last exactly SETTLE cycles, matching the two register stages between dbgsel and the mux compare; the FSM SHALL then enter HOLD with dbg_valid=1 and the dwell counter loaded from dwell.
REQ-018 A dwell value of 0 SHALL be treated as 1.
REQ-019 HOLD SHALL last exactly max(dwell,1) cycles with dbg_valid=1; the FSM SHALL then return to IDLE with gnt=0 and dbg_valid=0.
REQ-020 dwell SHALL be sampled only on entry to HOLD.
REQ-021 If the granted requester deasserts req in SWITCH or HOLD, the FSM SHALL enter IDLE on the next edge and clear gnt and dbg_valid.
REQ-022 IDLE SHALL last at least one cycle between grants, so two owners never have back-to-back grants.
REQ-023 dbgsel SHALL remain constant from grant until the FSM leaves HOLD; req_sel changes during that time SHALL be ignored.
REQ-024 A request arriving while the FSM is not in IDLE SHALL wait; no preemption.

Reset
REQ-025 While rstn=0, the block SHALL asynchronously force state=IDLE, gnt=0, dbgsel=0, dbg_valid=0, busy=0, counters=0 and rr pointer=0, including mid-SWITCH or mid-HOLD.
REQ-026 After rstn rises, the first arbitration SHALL occur on the first clock edge that samples rstn=1.

Configuration
REQ-027 With DBG_SEL_PARK_EN defined, dbgsel SHALL return to 0 whenever the FSM enters IDLE.
REQ-028 Without DBG_SEL_PARK_EN, dbgsel SHALL hold the last owner's code while in IDLE.

Structure
REQ-029 Package dbg_sel_pkg SHALL hold the state enum typedef and the constant SETTLE=2.
REQ-030 Round-robin selection SHALL be implemented in a sub-module, dbg_sel_rr_arb, with inputs req and pointer and a one-hot winner output.

Verification
REQ-031 Bench SHALL cover: req=0001, req_sel0=40, dwell=3 -> gnt=0001 and dbgsel=40 at cycle+1, dbg_valid high at cycles +3..+5, low at +6.
REQ-032 Bench SHALL cover: req=1111 held for 8 grants -> grant order 0,1,2,3,0,1,2,3 with at least one IDLE cycle between grants.
REQ-033 Bench SHALL cover: dwell=0 -> dbg_valid high for exactly 1 cycle.
REQ-034 Bench SHALL cover: owner drops req during HOLD -> gnt=0 and dbg_valid=0 on the next edge; dbgsel=0 only if DBG_SEL_PARK_EN is defined.
REQ-035 Bench SHALL cover: rstn pulsed low mid-SWITCH -> all outputs 0 immediately, without waiting for a clock edge; next grant goes to index 0.
REQ-036 Bench SHALL cover: req_sel0 changed from 40 to 90 during HOLD -> dbgsel stays 40 until IDLE.
